// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter from several masters onto one RAM port,
// with a FIFO that routes each response back to the master that issued it.
module ram_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_req,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]            m_err,
    output logic                              s_req,
    output logic                              s_we,
    output logic [DATA_WIDTH/8-1:0]           s_be,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    input  logic                              s_gnt,
    input  logic                              s_rvalid,
    input  logic                              s_err,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    output logic                              proto_err
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] rr_ptr, lock_idx, rr_sel, sel, head;
    logic          locked, rr_found, hs, push, pop, full;
    int            rr_idx;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] fifo_mem [MAX_OUTSTANDING];

    always_comb begin
        rr_found = 1'b0;
        rr_sel   = '0;
        rr_idx   = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            rr_idx = (int'(rr_ptr) + k) % NUM_MASTERS;
            if (!rr_found && m_req[rr_idx]) begin
                rr_found = 1'b1;
                rr_sel   = IW'(rr_idx);
            end
        end
    end

    // A stalled request keeps its master even if that master drops m_req.
    assign sel     = locked ? lock_idx : rr_sel;
    assign full    = count == CW'(MAX_OUTSTANDING);
    assign s_req   = (locked || |m_req) && !full && !reset;
    assign hs      = s_req && s_gnt;
    assign push    = hs;
    assign pop     = s_rvalid && count != '0;
    assign head    = fifo_mem[rd_ptr];
    assign m_gnt   = hs ? NUM_MASTERS'(1) << sel : '0;
    assign s_we    = s_req && m_we[sel];
    assign s_be    = s_req ? m_be[sel*BW +: BW] : '0;
    assign s_addr  = s_req ? m_addr[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_wdata = s_req ? m_wdata[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_rvalid  = pop ? NUM_MASTERS'(1) << head : '0;
    assign m_err     = (pop && s_err) ? NUM_MASTERS'(1) << head : '0;
    assign proto_err = s_rvalid && count == '0 && !reset;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_rdata
        assign m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = (pop && head == IW'(i)) ? s_rdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (hs) begin
            locked <= 1'b0;
            rr_ptr <= sel == IW'(NUM_MASTERS - 1) ? '0 : sel + 1'b1;
        end else if (s_req) begin
            locked   <= 1'b1;
            lock_idx <= sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= sel;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with scoreboard queues for grants,
// responses and protocol errors, checked by an independent monitor.
module tb_ram_arbiter;
    logic        clk, reset;
    logic [1:0]  m_req, m_gnt, m_we, m_rvalid, m_err;
    logic [7:0]  m_be;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err, proto_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h2000_0000;
    localparam logic [31:0] W0 = 32'h0000_AAAA, W1 = 32'h0000_BBBB;

    typedef struct { logic [1:0] gnt; logic we; logic [31:0] addr; logic [31:0] wdata; } gnt_t;
    typedef struct { logic [1:0] rv; logic [63:0] data; logic [1:0] err; } rsp_t;
    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    int   perr_q[$];
    gnt_t mg;
    rsp_t mr;
    int   errors = 0, checks = 0;

    ram_arbiter dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_gnt(m_gnt), .m_we(m_we), .m_be(m_be),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input int i);
        gnt_q.push_back('{gnt: i ? 2'b10 : 2'b01, we: i ? 1'b0 : 1'b1,
                          addr: i ? A1 : A0, wdata: i ? W1 : W0});
    endtask

    task automatic exp_rsp(input logic [1:0] rv, input logic [63:0] data, input logic [1:0] err);
        rsp_q.push_back('{rv: rv, data: data, err: err});
    endtask

    always @(negedge clk) begin
        if (m_gnt != 2'b00) begin
            if (gnt_q.size() == 0) chk("unexpected_gnt", {62'b0, m_gnt}, 64'b0);
            else begin
                mg = gnt_q.pop_front();
                chk("gnt", {62'b0, m_gnt}, {62'b0, mg.gnt});
                chk("gnt_addr", {32'b0, s_addr}, {32'b0, mg.addr});
                chk("gnt_wdata", {31'b0, s_we, s_wdata}, {31'b0, mg.we, mg.wdata});
            end
        end
        if (m_rvalid != 2'b00 || m_err != 2'b00) begin
            if (rsp_q.size() == 0) chk("unexpected_rsp", {62'b0, m_rvalid}, 64'b0);
            else begin
                mr = rsp_q.pop_front();
                chk("rsp_rvalid", {60'b0, m_err, m_rvalid}, {60'b0, mr.err, mr.rv});
                chk("rsp_rdata", m_rdata, mr.data);
            end
        end
        if (proto_err) begin
            if (perr_q.size() == 0) chk("unexpected_proto_err", 64'd1, 64'd0);
            else begin
                void'(perr_q.pop_front());
                chk("perr_m_rvalid", {62'b0, m_rvalid}, 64'b0);
            end
        end
    end

    initial begin
        reset = 1'b1; m_req = 0; s_gnt = 0; s_rvalid = 0; s_err = 0; s_rdata = 0;
        m_we = 2'b01; m_be = 8'hF3; m_addr = {A1, A0}; m_wdata = {W1, W0};
        repeat (2) @(posedge clk);
        #1;
        m_req = 2'b11; s_gnt = 1; s_rvalid = 1;
        #1;
        chk("rst_s_req", {63'b0, s_req}, 64'd0);
        chk("rst_m_gnt", {62'b0, m_gnt}, 64'd0);
        chk("rst_m_rvalid", {62'b0, m_rvalid}, 64'd0);
        chk("rst_proto_err", {63'b0, proto_err}, 64'd0);
        m_req = 0; s_gnt = 0; s_rvalid = 0;
        step();
        reset = 1'b0;
        // alternating grants with a response popping every following cycle
        m_req = 2'b11; s_gnt = 1; exp_gnt(0); step();
        chk("rr_ptr_a", {63'b0, dut.rr_ptr}, 64'd1);
        s_rvalid = 1; s_rdata = 32'h1111_0001; exp_gnt(1); exp_rsp(2'b01, {32'h0, 32'h1111_0001}, 2'b00); step();
        chk("rr_ptr_b", {63'b0, dut.rr_ptr}, 64'd0);
        chk("count_pushpop", {62'b0, dut.count}, 64'd1);
        s_rdata = 32'h2222_0002; exp_gnt(0); exp_rsp(2'b10, {32'h2222_0002, 32'h0}, 2'b00); step();
        chk("rr_ptr_c", {63'b0, dut.rr_ptr}, 64'd1);
        s_rdata = 32'h3333_0003; exp_gnt(1); exp_rsp(2'b01, {32'h0, 32'h3333_0003}, 2'b00); step();
        m_req = 0; s_gnt = 0; s_err = 1; s_rdata = 32'h4444_0004;
        exp_rsp(2'b10, {32'h4444_0004, 32'h0}, 2'b10); step();
        s_rvalid = 0; s_err = 0;
        // lock: master 1 arrives with higher priority but must not preempt
        m_req = 2'b01; s_gnt = 1; exp_gnt(0); step();
        s_gnt = 0; s_rvalid = 1; s_rdata = 32'h5555_0005; exp_rsp(2'b01, {32'h0, 32'h5555_0005}, 2'b00);
        #1;
        chk("lock_s_req", {63'b0, s_req}, 64'd1);
        chk("lock_addr0", {32'b0, s_addr}, {32'b0, A0});
        step();
        s_rvalid = 0; m_req = 2'b11; #1;
        chk("lock_addr1", {32'b0, s_addr}, {32'b0, A0});
        step();
        #1;
        chk("lock_addr2", {32'b0, s_addr}, {32'b0, A0});
        step();
        s_gnt = 1; exp_gnt(0); step();
        m_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h6666_0006; exp_rsp(2'b01, {32'h0, 32'h6666_0006}, 2'b00); step();
        s_rvalid = 0;
        // fill the FIFO; s_req must drop even while a pop happens
        m_req = 2'b11; s_gnt = 1; exp_gnt(1); step();
        exp_gnt(0); step();
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; exp_rsp(2'b10, {32'hDEAD_BEEF, 32'h0}, 2'b00);
        #1;
        chk("full_s_req", {63'b0, s_req}, 64'd0);
        step();
        m_req = 0; s_gnt = 0; s_rdata = 32'h7777_0007; exp_rsp(2'b01, {32'h0, 32'h7777_0007}, 2'b00); step();
        // response with nothing outstanding
        s_rdata = 32'h8888_0008; perr_q.push_back(1);
        #1;
        chk("perr_m_rvalid_direct", {62'b0, m_rvalid}, 64'd0);
        step();
        s_rvalid = 0; #1;
        chk("perr_one_cycle", {63'b0, proto_err}, 64'd0);
        step();
        // async reset with two outstanding
        m_req = 2'b11; s_gnt = 1; exp_gnt(1); step();
        exp_gnt(0); step();
        s_rvalid = 1; s_rdata = 32'h9999_0009;
        #1;
        chk("pre_reset_rvalid", {62'b0, m_rvalid}, 64'd2);
        reset = 1'b1;
        #1;
        chk("async_m_rvalid", {62'b0, m_rvalid}, 64'd0);
        chk("async_s_req", {63'b0, s_req}, 64'd0);
        chk("async_proto_err", {63'b0, proto_err}, 64'd0);
        chk("async_count", {62'b0, dut.count}, 64'd0);
        chk("async_rr_ptr", {63'b0, dut.rr_ptr}, 64'd0);
        step();
        reset = 1'b0; m_req = 0; s_gnt = 0; perr_q.push_back(1); step();
        s_rvalid = 0; m_req = 2'b11; s_gnt = 1; exp_gnt(0); step();
        m_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hAAAA_000A; exp_rsp(2'b01, {32'h0, 32'hAAAA_000A}, 2'b00); step();
        s_rvalid = 0;
        repeat (3) step();
        chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        chk("perr_q_drained", 64'(perr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of master ports (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, depth of the response-routing FIFO (1..8).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have m_req  in  NUM_MASTERS  per-master request.
REQ-007 SHALL have m_gnt  out  NUM_MASTERS  per-master grant.
REQ-008 SHALL have m_we  in  NUM_MASTERS  per-master write enable.
REQ-009 SHALL have m_be  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte enables (packed, master 0 at LSBs).
REQ-010 SHALL have m_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master address (packed).
REQ-011 SHALL have m_wdata  in  NUM_MASTERS*DATA_WIDTH  per-master write data (packed).
REQ-012 SHALL have m_rvalid  out  NUM_MASTERS, m_rdata  out  NUM_MASTERS*DATA_WIDTH, m_err  out  NUM_MASTERS  per-master response.
REQ-013 SHALL have slave port s_req/s_we out 1, s_be out DATA_WIDTH/8, s_addr out ADDR_WIDTH, s_wdata out DATA_WIDTH, s_gnt/s_rvalid/s_err in 1, s_rdata in DATA_WIDTH.
REQ-014 SHALL have proto_err  out  1  one-cycle pulse when s_rvalid arrives with no outstanding transaction.

Function
REQ-015 SHALL arbitrate round-robin: highest priority is the requesting master at or above pointer rr_ptr, wrapping modulo NUM_MASTERS.
REQ-016 SHALL drive s_req high when any m_req is high, FIFO not full, and no reset; s_we/s_be/s_addr/s_wdata SHALL be the selected master's fields (zero when s_req low).
REQ-017 SHALL assert m_gnt[i] combinationally (zero latency) only when s_req and s_gnt are high and master i is selected; all other m_gnt bits low.
REQ-018 SHALL lock the selection while s_req is high and s_gnt low: selected index held in a register; new requests from higher-priority masters do not preempt.
REQ-019 SHALL release the lock on the handshake cycle (s_req and s_gnt) and set rr_ptr to (granted index + 1) mod NUM_MASTERS.
REQ-020 SHALL, on each handshake, push the granted index into the routing FIFO.
REQ-021 SHALL, on s_rvalid with FIFO non-empty, route s_rvalid/s_rdata/s_err combinationally to the head master and pop; other masters see m_rvalid=0, m_err=0, m_rdata=0.
REQ-022 SHALL support simultaneous push and pop in one cycle; occupancy then unchanged, ordering preserved.
REQ-023 SHALL deassert s_req when the FIFO holds MAX_OUTSTANDING entries, even if s_rvalid pops in the same cycle (full gating from registered count only).
REQ-024 SHALL, on s_rvalid with FIFO empty, drop the response (no m_rvalid) and pulse proto_err for one cycle.
REQ-025 SHALL wrap FIFO read/write pointers modulo MAX_OUTSTANDING; occupancy counter SHALL be ceil(log2(MAX_OUTSTANDING+1)) bits.
REQ-026 SHALL, if a locked master drops m_req before grant, keep the lock and continue to present its stored index (master protocol violation; no recovery required).

Reset
REQ-027 SHALL, while reset is high, force rr_ptr=0, lock cleared, FIFO empty (pointers and count 0), proto_err=0, s_req=0, all m_gnt=0, all m_rvalid=0.
REQ-028 SHALL discard outstanding FIFO entries on reset mid-operation; responses arriving after reset with FIFO empty raise proto_err.

Verification
REQ-029 SHALL verify: NUM_MASTERS=2, m_req=2'b11 held, s_gnt=1 every cycle -> m_gnt alternates 01,10,01,10; rr_ptr alternates 1,0.
REQ-030 SHALL verify: m_req[0]=1, s_gnt=0 for 3 cycles, m_req[1] rises at cycle 1 -> s_addr stays master 0's address all 3 cycles; grant at cycle 4 goes to master 0.
REQ-031 SHALL verify: MAX_OUTSTANDING=2, two grants (master 1 then 0), no s_rvalid -> s_req low on third cycle; s_rvalid with s_rdata=32'hDEADBEEF -> m_rvalid=2'b10, m_rdata[63:32]=32'hDEADBEEF.
REQ-032 SHALL verify: FIFO count 1, handshake and s_rvalid same cycle -> count stays 1, response to older master, next response to newer master.
REQ-033 SHALL verify: s_rvalid=1 with FIFO empty -> proto_err=1 for exactly one cycle, m_rvalid=0.
REQ-034 SHALL verify: reset asserted mid-cycle with 2 outstanding -> outputs zero asynchronously, count=0 after release, next grant goes to master 0.
